// File: rtl/md_hilo_ctrl_pkg.sv
// Shared encodings and default latencies for the multiply/divide HI/LO controller.
package md_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_hilo_ctrl_arith.sv
// Combinational 64-bit product and quotient/remainder for the HI/LO unit.
// Divide-by-zero and the signed overflow case are resolved here so the
// controller only has to latch results.
module md_arith
  import md_hilo_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic               mul_signed;
  logic               div_signed;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign mul_signed = (op_i == MD_MULT);
  assign div_signed = (op_i == MD_DIV);
  assign a_sx       = {{32{a_i[31]}}, a_i};
  assign b_sx       = {{32{b_i[31]}}, b_i};
  assign a_s        = a_i;
  assign b_s        = b_i;

  // Product: low 64 bits of the sign- or zero-extended operands.
  always_comb begin
    prod_o = 64'd0;
    if (mul_signed) begin
      prod_o = a_sx * b_sx;
    end else begin
      prod_o = {32'd0, a_i} * {32'd0, b_i};
    end
  end

  // Quotient/remainder: divide-by-zero returns all-ones / dividend; the
  // signed most-negative / -1 case wraps back to the dividend with zero remainder.
  always_comb begin
    quo_o = 32'd0;
    rem_o = 32'd0;
    if (b_i == 32'd0) begin
      quo_o = 32'hFFFF_FFFF;
      rem_o = a_i;
    end else if (div_signed) begin
      if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
        quo_o = 32'h8000_0000;
        rem_o = 32'd0;
      end else begin
        quo_o = a_s / b_s;
        rem_o = a_s % b_s;
      end
    end else begin
      quo_o = a_i / b_i;
      rem_o = a_i % b_i;
    end
  end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and architectural HI/LO registers.
//
//   state   | meaning
//   ST_IDLE | no operation in flight; accepts MULT*/DIV*/MTHI/MTLO
//   ST_RUN  | result pending; counts down, commits HI/LO at cnt==1
module md_hilo_ctrl
  import md_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_data_E,
  input  logic [31:0] rt_data_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        op_is_md;

  md_arith u_arith (
    .op_i   (md_op_E),
    .a_i    (rs_data_E),
    .b_i    (rt_data_E),
    .prod_o (prod),
    .quo_o  (quo),
    .rem_o  (rem)
  );

  assign op_is_md = (md_op_E >= MD_MULT) && (md_op_E <= MD_DIVU);
  assign busy     = (state_q == ST_RUN);
  assign stall_D  = md_use_D & (busy | (start_E & op_is_md));
  assign HI       = hi_q;
  assign LO       = lo_q;

  // State, counter, pending results and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Issue in IDLE, count down in RUN; start_E during RUN is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_E) begin
          case (md_op_E)
            MD_MULT, MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod;
              cnt_d   = MUL_CNT;
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_lo_d = quo;
              pend_hi_d = rem;
              cnt_d     = DIV_CNT;
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = rs_data_E;
            MD_MTLO: lo_d = rs_data_E;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed plus randomized check of md_hilo_ctrl against an arithmetic reference model.
module tb_md_hilo_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [2:0]  md_op_E;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: cycles of busy remaining and expected registers.
  int          m_rem = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;

  md_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_E   (start_E),
    .md_op_E   (md_op_E),
    .rs_data_E (rs_data_E),
    .rt_data_E (rt_data_E),
    .md_use_D  (md_use_D),
    .busy      (busy),
    .stall_D   (stall_D),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural result of a mult/div computed with 64-bit integer arithmetic.
  function automatic void ref_md(input int op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin sq = sa / sb; sr = sa - sq * sb; lo = sq[31:0]; hi = sr[31:0]; end
      end
      4: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin uq = ua / ub; ur = ua - uq * ub; lo = uq[31:0]; hi = ur[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // One cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic u);
    logic exp_stall;
    @(negedge clk);
    start_E   = s;
    md_op_E   = op;
    rs_data_E = a;
    rt_data_E = b;
    md_use_D  = u;
    #1;
    exp_stall = u && ((m_rem > 0) || (s && op >= 3'd1 && op <= 3'd4));
    chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
    chk("stall_D", {31'd0, stall_D}, {31'd0, exp_stall});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s) begin
      case (op)
        3'd1, 3'd2: begin ref_md(int'(op), a, b, m_phi, m_plo); m_rem = MUL_LAT; end
        3'd3, 3'd4: begin ref_md(int'(op), a, b, m_phi, m_plo); m_rem = DIV_LAT; end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom, u);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b0;
    start_E   = 1'b0;
    md_op_E   = 3'd0;
    rs_data_E = 32'd0;
    rt_data_E = 32'd0;
    md_use_D  = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT -2 * 3
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MUL_LAT, 1'b0);
    #1;
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);
    chk("mult_busy", {31'd0, busy}, 32'd0);

    // MULTU max * max
    step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(MUL_LAT, 1'b0);
    #1;
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);

    // DIV -7 / 2 with D-stage use throughout and a stray start while busy
    step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    step(1'b1, 3'd4, 32'd7, 32'd0, 1'b1);
    idle(DIV_LAT - 1, 1'b1);
    #1;
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);
    idle(1, 1'b1);

    // DIVU by zero
    step(1'b1, 3'd4, 32'd7, 32'd0, 1'b0);
    idle(DIV_LAT, 1'b0);
    #1;
    chk("divu0_LO", LO, 32'hFFFF_FFFF);
    chk("divu0_HI", HI, 32'd7);

    // Signed overflow
    step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DIV_LAT, 1'b0);
    #1;
    chk("divov_LO", LO, 32'h8000_0000);
    chk("divov_HI", HI, 32'd0);

    // Back-to-back MTHI / MTLO with D-stage use
    step(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b1);
    step(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1);
    #1;
    chk("mthi_HI", HI, 32'h1234_5678);
    chk("mtlo_LO", LO, 32'h9ABC_DEF0);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    idle(1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
           1'($urandom_range(0, 1)));
    end
    idle(DIV_LAT, 1'b0);

    // Reset in the third cycle of a MULT aborts it
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    step(1'b1, 3'd1, 32'd1234, 32'd5678, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_HI", HI, 32'd0);
    chk("arst_LO", LO, 32'd0);
    m_rem = 0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    idle(MUL_LAT + 3, 1'b1);
    #1;
    chk("post_rst_HI", HI, 32'd0);
    chk("post_rst_LO", LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
